// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_pkg;

    // Byte offsets within the 12-byte register window
    localparam logic [3:0] PRI_OFF  = 4'd0;
    localparam logic [3:0] ENA_OFF  = 4'd4;
    localparam logic [3:0] ACT_OFF  = 4'd8;
    localparam int         NUM_REGS = 12;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACKED
    } irq_state_t;

    typedef logic [1:0] prio_t;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational 32-way arbiter: highest group priority wins, ties go to lowest index.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0] act_i,
    input  logic [NUM_IRQ-1:0] ena_i,
    input  logic [NUM_IRQ-1:0] pri_i,
    output logic               win_valid_o,
    output logic [4:0]         win_idx_o,
    output prio_t              win_lvl_o
);

    // Strict '>' starting from level 0 masks priority-0 sources and keeps the lowest index on ties
    always_comb begin
        win_valid_o = 1'b0;
        win_idx_o   = '0;
        win_lvl_o   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (act_i[i] && ena_i[i] && (pri_i[2*(i/2) +: 2] > win_lvl_o)) begin
                win_valid_o = 1'b1;
                win_idx_o   = 5'(i);
                win_lvl_o   = pri_i[2*(i/2) +: 2];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches peripheral pulses, masks/prioritises them and
// runs a request/ack handshake with the CPU; register block on the CPU bus.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [23:0] IRQ_BASE = 24'h002020,
    parameter int          NUM_IRQ  = 32,
    parameter logic [7:0]  VEC_BASE = 8'h03
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ce_cpu,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                bus_write,
    input  logic [23:0]         bus_address_in,
    input  logic [7:0]          bus_data_in,
    output logic [7:0]          bus_data_out,
    output logic                irq_req,
    output logic [7:0]          irq_vector,
    output logic [1:0]          irq_level,
    input  logic                irq_ack
);

    logic [NUM_IRQ-1:0] pri_q, pri_d;
    logic [NUM_IRQ-1:0] ena_q, ena_d;
    logic [NUM_IRQ-1:0] act_q, act_d;
    logic [NUM_IRQ-1:0] act_clr;

    irq_state_t state_q, state_d;
    logic       req_q, req_d;
    logic [7:0] vec_q, vec_d;
    prio_t      lvl_q, lvl_d;

    logic       win_valid;
    logic [4:0] win_idx;
    prio_t      win_lvl;

    logic [23:0] off;
    logic        in_win;
    logic [4:0]  byte_lsb;

    assign off      = bus_address_in - IRQ_BASE;
    assign in_win   = (off < 24'(NUM_REGS));
    assign byte_lsb = {off[1:0], 3'b000};

    always_comb begin
        pri_d   = pri_q;
        ena_d   = ena_q;
        act_clr = '0;
        if (bus_write && in_win) begin
            case (off[3:2])
                PRI_OFF[3:2]: pri_d[byte_lsb +: 8]   = bus_data_in;
                ENA_OFF[3:2]: ena_d[byte_lsb +: 8]   = bus_data_in;
                ACT_OFF[3:2]: act_clr[byte_lsb +: 8] = bus_data_in;
                default:      ;
            endcase
        end
        // A new pulse beats a same-cycle software clear
        act_d = (act_q & ~act_clr) | irq_in;
    end

    always_comb begin
        bus_data_out = 8'h00;
        if (in_win) begin
            case (off[3:2])
                PRI_OFF[3:2]: bus_data_out = pri_q[byte_lsb +: 8];
                ENA_OFF[3:2]: bus_data_out = ena_q[byte_lsb +: 8];
                ACT_OFF[3:2]: bus_data_out = act_q[byte_lsb +: 8];
                default:      bus_data_out = 8'h00;
            endcase
        end
    end

    irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
        .act_i       (act_q),
        .ena_i       (ena_q),
        .pri_i       (pri_q),
        .win_valid_o (win_valid),
        .win_idx_o   (win_idx),
        .win_lvl_o   (win_lvl)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        lvl_d   = lvl_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    vec_d   = VEC_BASE + {3'b000, win_idx};
                    lvl_d   = win_lvl;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = ACKED;
                    req_d   = 1'b0;
                end else if (!win_valid) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (win_lvl > lvl_q) begin
                    vec_d = VEC_BASE + {3'b000, win_idx};
                    lvl_d = win_lvl;
                end
            end
            ACKED:   state_d = IDLE;
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q   <= '0;
            ena_q   <= '0;
            act_q   <= '0;
            state_q <= IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            lvl_q   <= '0;
        end else if (clk_ce_cpu) begin
            pri_q   <= pri_d;
            ena_q   <= ena_d;
            act_q   <= act_d;
            state_q <= state_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            lvl_q   <= lvl_d;
        end
    end

    assign irq_req    = req_q;
    assign irq_vector = vec_q;
    assign irq_level  = lvl_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register access, arbitration, pre-emption and handshake.
module tb_irq_controller;

    localparam logic [23:0] BASE = 24'h002020;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_ce_cpu;
    logic [31:0] irq_in;
    logic        bus_write;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        irq_req;
    logic [7:0]  irq_vector;
    logic [1:0]  irq_level;
    logic        irq_ack;

    int checks   = 0;
    int failures = 0;

    irq_controller dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce_cpu     (clk_ce_cpu),
        .irq_in         (irq_in),
        .bus_write      (bus_write),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_level      (irq_level),
        .irq_ack        (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] addr, input logic [7:0] data);
        bus_address_in = addr;
        bus_data_in    = data;
        bus_write      = 1'b1;
        tick();
        bus_write      = 1'b0;
    endtask

    task automatic rd(input logic [23:0] addr, output logic [7:0] data);
        bus_address_in = addr;
        #1;
        data = bus_data_out;
    endtask

    task automatic pulse(input logic [31:0] mask);
        irq_in = mask;
        tick();
        irq_in = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    logic [7:0] r;

    initial begin
        reset = 1'b1; clk_ce_cpu = 1'b1; irq_in = '0; bus_write = 1'b0;
        bus_address_in = '0; bus_data_in = '0; irq_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_req", irq_req, 0);
        check("rst_vec", irq_vector, 0);
        check("rst_lvl", irq_level, 0);
        rd(BASE + 0, r);  check("rst_pri0", r, 0);
        rd(BASE + 4, r);  check("rst_ena0", r, 0);
        rd(BASE + 8, r);  check("rst_act0", r, 0);

        // Single source, then ack and clear during ACKED
        wr(BASE + 0, 8'h03);
        wr(BASE + 4, 8'h01);
        rd(BASE + 0, r);  check("pri0_rd", r, 8'h03);
        rd(BASE + 12, r); check("out_of_win", r, 0);
        pulse(32'h1);
        rd(BASE + 8, r);  check("t1_act0", r, 8'h01);
        check("t1_req_latency", irq_req, 0);
        tick();
        check("t1_req", irq_req, 1);
        check("t1_vec", irq_vector, 8'h03);
        check("t1_lvl", irq_level, 3);
        ack();
        check("t2_req_acked", irq_req, 0);
        rd(BASE + 8, r);  check("t2_act_kept", r, 8'h01);
        wr(BASE + 8, 8'h01);
        check("t2_req_after", irq_req, 0);
        rd(BASE + 8, r);  check("t2_act_clr", r, 0);
        tick();
        check("t2_no_new_req", irq_req, 0);

        // Priority arbitration and pre-emption before ack
        wr(BASE + 0, 8'h24);
        wr(BASE + 4, 8'h24);
        pulse(32'h24);
        tick();
        check("t3_req", irq_req, 1);
        check("t3_vec", irq_vector, 8'h08);
        check("t3_lvl", irq_level, 2);
        wr(BASE + 0, 8'h27);
        wr(BASE + 4, 8'h25);
        check("t3_no_equal_update", irq_vector, 8'h08);
        pulse(32'h1);
        tick();
        check("t3_pre_vec", irq_vector, 8'h03);
        check("t3_pre_lvl", irq_level, 3);
        ack();
        wr(BASE + 8, 8'h25);
        tick();
        check("t3_idle", irq_req, 0);

        // Equal priority: lowest index first
        wr(BASE + 0, 8'h20);
        wr(BASE + 4, 8'h30);
        pulse(32'h30);
        tick();
        check("t4_vec", irq_vector, 8'h07);
        ack();
        wr(BASE + 8, 8'h10);
        tick();
        check("t4_req2", irq_req, 1);
        check("t4_vec2", irq_vector, 8'h08);
        ack();
        wr(BASE + 8, 8'h20);
        tick();
        check("t4_idle", irq_req, 0);

        // Clock enable low freezes state
        clk_ce_cpu = 1'b0;
        pulse(32'h80);
        wr(BASE + 4, 8'hFF);
        clk_ce_cpu = 1'b1;
        rd(BASE + 8, r);  check("ce_act_frozen", r, 0);
        rd(BASE + 4, r);  check("ce_ena_frozen", r, 8'h30);

        // Disabled source still shows in ACT; enabling raises the request
        wr(BASE + 1, 8'h01);
        pulse(32'h200);
        tick();
        rd(BASE + 9, r);  check("t5_act1", r, 8'h02);
        check("t5_no_req", irq_req, 0);
        wr(BASE + 5, 8'h02);
        tick();
        check("t5_req", irq_req, 1);
        check("t5_vec", irq_vector, 8'h0C);
        check("t5_lvl", irq_level, 1);

        // Withdraw on disable, then re-request
        wr(BASE + 5, 8'h00);
        tick();
        check("t5_withdraw", irq_req, 0);
        wr(BASE + 5, 8'h02);
        tick();
        check("t5_rereq", irq_req, 1);

        // Set beats same-cycle write-1-clear
        irq_in = 32'h8;
        wr(BASE + 8, 8'h08);
        irq_in = '0;
        rd(BASE + 8, r);  check("t6_set_wins", r, 8'h08);

        // Reset during REQ with a pending ack
        reset = 1'b1; irq_ack = 1'b1;
        tick();
        reset = 1'b0; irq_ack = 1'b0;
        check("t6_rst_req", irq_req, 0);
        check("t6_rst_vec", irq_vector, 0);
        check("t6_rst_lvl", irq_level, 0);
        rd(BASE + 0, r);  check("t6_rst_pri0", r, 0);
        rd(BASE + 1, r);  check("t6_rst_pri1", r, 0);
        rd(BASE + 5, r);  check("t6_rst_ena1", r, 0);
        rd(BASE + 8, r);  check("t6_rst_act0", r, 0);
        rd(BASE + 9, r);  check("t6_rst_act1", r, 0);
        tick();
        check("t6_idle_after", irq_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
